// File: rtl/line_window_buffer.sv
// Line ring buffer that stores NUM_LINES image lines and exposes a WIN_ROWS x TAPS
// pixel window, with right-edge replication, for streaming 2-D filters.
`timescale 1ns/1ps
module line_window_buffer #(
  parameter int DATA_W    = 8,
  parameter int LINE_LEN  = 640,
  parameter int NUM_LINES = 4,
  parameter int WIN_ROWS  = 3,
  parameter int TAPS      = 3
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [DATA_W-1:0]                   pixel,
  input  logic                                pixel_valid,
  output logic                                pixel_ready,
  input  logic                                rd_pixel,
  output logic                                window_valid,
  output logic [WIN_ROWS*TAPS*DATA_W-1:0]     window_out,
  output logic [$clog2(NUM_LINES+1)-1:0]      lines_avail,
  output logic                                overflow
);

  localparam int CW = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam int LW = $clog2(NUM_LINES);
  localparam int FW = $clog2(NUM_LINES + 1);
  localparam int unsigned LL = LINE_LEN;
  localparam int unsigned NL = NUM_LINES;
  localparam logic [CW-1:0] LAST_COL  = CW'(LINE_LEN - 1);
  localparam logic [LW-1:0] LAST_LINE = LW'(NUM_LINES - 1);
  localparam logic [FW-1:0] FULL_CNT  = FW'(NUM_LINES);
  localparam logic [FW-1:0] WIN_CNT   = FW'(WIN_ROWS);
  localparam logic [FW-1:0] ONE_CNT   = FW'(1);

  // Pointers wrap explicitly so non-power-of-two geometries stay in range.
  function automatic logic [CW-1:0] col_inc(input logic [CW-1:0] c);
    if (c == LAST_COL) return {CW{1'b0}};
    else               return c + CW'(1);
  endfunction

  function automatic logic [LW-1:0] line_inc(input logic [LW-1:0] l);
    if (l == LAST_LINE) return {LW{1'b0}};
    else                return l + LW'(1);
  endfunction

  function automatic logic [LW-1:0] line_off(input logic [LW-1:0] base, input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    return LW'(s % NL);
  endfunction

  function automatic logic [CW-1:0] tap_col(input logic [CW-1:0] base, input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= LL) return LAST_COL;
    else         return CW'(s);
  endfunction

  logic [DATA_W-1:0] mem_r [NUM_LINES][LINE_LEN];

  logic [LW-1:0] wr_line_r, rd_line_r;
  logic [CW-1:0] wr_col_r, rd_col_r;
  logic [FW-1:0] lines_full_r, lines_full_nx_s;
  logic          overflow_r, pixel_ready_r, window_valid_r;
  logic          wr_en_s, rd_en_s, wr_eol_s, rd_eol_s;

  // Handshake decode and next line count.
  always_comb begin
    wr_en_s  = pixel_valid && pixel_ready_r;
    rd_en_s  = rd_pixel && window_valid_r;
    wr_eol_s = wr_en_s && (wr_col_r == LAST_COL);
    rd_eol_s = rd_en_s && (rd_col_r == LAST_COL);
    case ({wr_eol_s, rd_eol_s})
      2'b10:   lines_full_nx_s = lines_full_r + ONE_CNT;
      2'b01:   lines_full_nx_s = lines_full_r - ONE_CNT;
      default: lines_full_nx_s = lines_full_r;
    endcase
  end

  // Pointer, count and status registers; flags track the next count so they
  // reflect a completed line from the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_line_r      <= {LW{1'b0}};
      wr_col_r       <= {CW{1'b0}};
      rd_line_r      <= {LW{1'b0}};
      rd_col_r       <= {CW{1'b0}};
      lines_full_r   <= {FW{1'b0}};
      overflow_r     <= 1'b0;
      pixel_ready_r  <= 1'b1;
      window_valid_r <= 1'b0;
    end else begin
      if (wr_en_s) begin
        wr_col_r <= col_inc(wr_col_r);
        if (wr_eol_s) wr_line_r <= line_inc(wr_line_r);
      end
      if (rd_en_s) begin
        rd_col_r <= col_inc(rd_col_r);
        if (rd_eol_s) rd_line_r <= line_inc(rd_line_r);
      end
      if (pixel_valid && !pixel_ready_r) overflow_r <= 1'b1;
      lines_full_r   <= lines_full_nx_s;
      pixel_ready_r  <= (lines_full_nx_s < FULL_CNT);
      window_valid_r <= (lines_full_nx_s >= WIN_CNT);
    end
  end

  // Line storage; deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) mem_r[wr_line_r][wr_col_r] <= pixel;
  end

  for (genvar r = 0; r < WIN_ROWS; r++) begin : g_row
    logic [LW-1:0] row_line_s;
    assign row_line_s = line_off(rd_line_r, r);
    for (genvar t = 0; t < TAPS; t++) begin : g_tap
      assign window_out[((r*TAPS)+t)*DATA_W +: DATA_W] = mem_r[row_line_s][tap_col(rd_col_r, t)];
    end
  end

  assign pixel_ready  = pixel_ready_r;
  assign window_valid = window_valid_r;
  assign lines_avail  = lines_full_r;
  assign overflow     = overflow_r;

endmodule

// File: tb/tb_line_window_buffer.sv
// Scoreboard bench for line_window_buffer: a line-queue model predicts the state
// after every edge and a negedge monitor compares it with the DUT.
`timescale 1ns/1ps
module tb_line_window_buffer;
  localparam int DW = 8, LL = 8, NL = 4, WR = 3, TP = 3;
  localparam int WW = WR*TP*DW;
  localparam int FW = $clog2(NL+1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] pixel = '0;
  logic          pixel_valid = 1'b0, rd_pixel = 1'b0;
  logic          pixel_ready, window_valid, overflow;
  logic [WW-1:0] window_out;
  logic [FW-1:0] lines_avail;

  always #5 clk = ~clk;

  line_window_buffer #(.DATA_W(DW), .LINE_LEN(LL), .NUM_LINES(NL), .WIN_ROWS(WR), .TAPS(TP)) dut (
    .clk(clk), .rst(rst), .pixel(pixel), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
    .rd_pixel(rd_pixel), .window_valid(window_valid), .window_out(window_out),
    .lines_avail(lines_avail), .overflow(overflow));

  typedef logic [DW-1:0] line_t [LL];
  typedef struct { bit wv; bit pr; int la; bit ov; logic [WW-1:0] win; } exp_t;

  line_t         lines_q[$];
  logic [DW-1:0] part_q[$];
  int            m_col = 0;
  bit            m_ovf = 1'b0;
  exp_t          exp_q[$];
  int            errors = 0, checks = 0;

  task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [WW-1:0] model_win();
    logic [WW-1:0] w = '0;
    for (int r = 0; r < WR; r++)
      for (int t = 0; t < TP; t++) begin
        int c = m_col + t;
        if (c > LL-1) c = LL-1;
        w[((r*TP)+t)*DW +: DW] = lines_q[r][c];
      end
    return w;
  endfunction

  function automatic logic [WW-1:0] row0(input int a, input int b, input int c);
    logic [WW-1:0] w = '0;
    w[3*DW-1:0] = {DW'(c), DW'(b), DW'(a)};
    return w;
  endfunction

  // One clock of stimulus; the model advances and pushes the expected post-edge state.
  task automatic step(input bit pv, input logic [DW-1:0] px, input bit rp);
    bit acc_w, acc_r;
    exp_t e;
    line_t l;
    pixel_valid = pv; pixel = px; rd_pixel = rp;
    acc_w = pv && (lines_q.size() < NL);
    acc_r = rp && (lines_q.size() >= WR);
    if (pv && !acc_w) m_ovf = 1'b1;
    @(posedge clk);
    if (acc_r) begin
      if (m_col == LL-1) begin m_col = 0; lines_q.delete(0); end
      else m_col++;
    end
    if (acc_w) begin
      part_q.push_back(px);
      if (part_q.size() == LL) begin
        for (int i = 0; i < LL; i++) l[i] = part_q[i];
        lines_q.push_back(l);
        part_q.delete();
      end
    end
    e.wv  = lines_q.size() >= WR;
    e.pr  = lines_q.size() < NL;
    e.la  = lines_q.size();
    e.ov  = m_ovf;
    e.win = e.wv ? model_win() : '0;
    exp_q.push_back(e);
    #1;
  endtask

  task automatic sync();
    @(negedge clk); #1;
    pixel_valid = 1'b0; rd_pixel = 1'b0;
  endtask

  // Reset asserted between edges; outputs must settle before the next edge.
  task automatic do_reset();
    sync();
    rst = 1'b1;
    #1;
    chk("rst_pixel_ready", WW'(pixel_ready), WW'(1));
    chk("rst_window_valid", WW'(window_valid), WW'(0));
    chk("rst_lines_avail", WW'(lines_avail), WW'(0));
    chk("rst_overflow", WW'(overflow), WW'(0));
    lines_q.delete(); part_q.delete(); m_col = 0; m_ovf = 1'b0;
    @(posedge clk); @(negedge clk); #2;
    rst = 1'b0;
  endtask

  task automatic write_ramp(input int n);
    for (int i = 0; i < n; i++) step(1'b1, DW'(i), 1'b0);
  endtask

  task automatic check_ramp_window(input string name);
    logic [WW-1:0] w = '0;
    for (int r = 0; r < WR; r++)
      for (int t = 0; t < TP; t++) w[((r*TP)+t)*DW +: DW] = DW'(r*LL + t);
    sync();
    chk({name, "_valid"}, WW'(window_valid), WW'(1));
    chk({name, "_win"}, window_out, w);
    chk({name, "_avail"}, WW'(lines_avail), WW'(3));
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sb_window_valid", WW'(window_valid), WW'(e.wv));
      chk("sb_pixel_ready", WW'(pixel_ready), WW'(e.pr));
      chk("sb_lines_avail", WW'(lines_avail), WW'(e.la));
      chk("sb_overflow", WW'(overflow), WW'(e.ov));
      if (e.wv) chk("sb_window", window_out, e.win);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    write_ramp(24);
    check_ramp_window("ramp");
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);
    sync(); chk("col5_row0", {{(WW-3*DW){1'b0}}, window_out[3*DW-1:0]}, row0(5, 6, 7));
    step(1'b0, '0, 1'b1);
    sync(); chk("col6_row0", {{(WW-3*DW){1'b0}}, window_out[3*DW-1:0]}, row0(6, 7, 7));
    step(1'b0, '0, 1'b1);
    sync(); chk("col7_row0", {{(WW-3*DW){1'b0}}, window_out[3*DW-1:0]}, row0(7, 7, 7));
    step(1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
    sync();
    chk("idle_read_avail", WW'(lines_avail), WW'(2));
    chk("idle_read_valid", WW'(window_valid), WW'(0));

    do_reset();
    write_ramp(32);
    sync(); chk("full_ready", WW'(pixel_ready), WW'(0));
    step(1'b1, 8'hAA, 1'b0);
    sync();
    chk("drop_overflow", WW'(overflow), WW'(1));
    chk("drop_avail", WW'(lines_avail), WW'(4));

    do_reset();
    write_ramp(4);
    do_reset();
    write_ramp(24);
    check_ramp_window("post_rst");

    for (int i = 0; i < 7; i++) step(1'b1, DW'(24 + i), 1'b1);
    step(1'b1, 8'd31, 1'b1);
    sync();
    chk("simul_avail", WW'(lines_avail), WW'(3));
    chk("simul_row0", {{(WW-3*DW){1'b0}}, window_out[3*DW-1:0]}, row0(8, 9, 10));

    for (int i = 0; i < 3000; i++) begin
      int rd_pct;
      rd_pct = ((i / 300) % 2 == 0) ? 3 : 9;
      step($urandom_range(0, 9) < 7, DW'($urandom), $urandom_range(0, 9) < rd_pct);
    end
    sync();
    chk("sb_drain", WW'(exp_q.size()), WW'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
